parallel_to_serial_conv: RTL and testbench

- Free-running PISO (parallel-in, serial-out) serializer.
- Whenever its internal shift register is empty, it captures a DATA_W-bit word from parallel_i and shifts it out one bit per clock on serial_o, qualified by valid_o.
- It has no input handshake; upstream keeps parallel_i stable around the load edge, and empty_o marks when the next word will be taken.
- Sits between a parallel data source and a single-wire serial sink.

---
 rtl/parallel_to_serial_conv.sv | 64 ++++++
 tb/tb_parallel_to_serial_conv.sv | 130 +++++++++++++
 2 files changed

// File: rtl/parallel_to_serial_conv.sv
// Free-running PISO serializer: loads parallel_i whenever empty, then shifts
// one bit per clock on serial_o (qualified by valid_o), with a one-cycle bubble between words.
module parallel_to_serial_conv #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] parallel_i,
  output logic              serial_o,
  output logic              valid_o,
  output logic              empty_o
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg = '0;
  logic [CW-1:0]     cnt   = '0;
  logic              serial_q = 1'b0;
  logic              valid_q  = 1'b0;
  logic              empty_q  = 1'b1;

  logic              out_bit;
  logic [DATA_W-1:0] shreg_shifted;

  always_comb begin
    out_bit       = 1'b0;
    shreg_shifted = '0;
    if (MSB_FIRST) begin
      out_bit       = shreg[DATA_W-1];
      shreg_shifted = {shreg[DATA_W-2:0], 1'b0};
    end else begin
      out_bit       = shreg[0];
      shreg_shifted = {1'b0, shreg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else if (cnt == '0) begin
      // Load edge: serial_q deliberately keeps its last value.
      shreg   <= parallel_i;
      cnt     <= CW'(DATA_W);
      valid_q <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      serial_q <= out_bit;
      shreg    <= shreg_shifted;
      cnt      <= cnt - CW'(1);
      valid_q  <= 1'b1;
      empty_q  <= (cnt == CW'(1));
    end
  end

  assign serial_o = serial_q;
  assign valid_o  = valid_q;
  assign empty_o  = empty_q;

endmodule

// File: tb/tb_parallel_to_serial_conv.sv
// Directed bench: a 4-bit LSB-first instance and an 8-bit MSB-first instance.
module tb_parallel_to_serial_conv;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset8 = 1'b1;
  logic [3:0] par4 = 4'b0000;
  logic [7:0] par8 = 8'h00;
  logic       ser4, val4, emp4;
  logic       ser8, val8, emp8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parallel_to_serial_conv #(.DATA_W(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .reset(reset), .parallel_i(par4),
    .serial_o(ser4), .valid_o(val4), .empty_o(emp4)
  );

  parallel_to_serial_conv #(.DATA_W(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .reset(reset8), .parallel_i(par8),
    .serial_o(ser8), .valid_o(val8), .empty_o(emp8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Compare serial/valid/empty of the selected instance.
  task automatic check3(input string tag, input bit sel8,
                        input logic s, input logic v, input logic e);
    if (sel8) begin
      check({tag, ".serial"}, ser8, s);
      check({tag, ".valid"},  val8, v);
      check({tag, ".empty"},  emp8, e);
    end else begin
      check({tag, ".serial"}, ser4, s);
      check({tag, ".valid"},  val4, v);
      check({tag, ".empty"},  emp4, e);
    end
  endtask

  // Expected bit stream given in output order: seq[0] is the first bit out.
  task automatic shift_word(input string tag, input bit sel8,
                            input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check3($sformatf("%s.bit%0d", tag, i), sel8, seq[i], 1'b1, (i == n - 1));
    end
  endtask

  initial begin
    // Reset held for two edges
    reset = 1'b1;
    tick();
    tick();
    check3("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check3("reset8", 1'b1, 1'b0, 1'b0, 1'b1);

    // First edge after reset loads 4'b1011
    par4  = 4'b1011;
    reset = 1'b0;
    tick();
    check3("load1011", 1'b0, 1'b0, 1'b0, 1'b0);
    par4 = 4'b0110;
    // LSB first: 1,1,0,1
    shift_word("w1011", 1'b0, 8'b0000_1011, 4);

    // Load 4'b0110; serial holds last bit (1) across the load
    tick();
    check3("load0110", 1'b0, 1'b1, 1'b0, 1'b0);
    par4 = 4'b1111;
    // Output order 0,1,1,0 despite parallel_i changing mid-word
    shift_word("w0110", 1'b0, 8'b0000_0110, 4);

    // Back-to-back: 0001 then 1000
    par4 = 4'b0001;
    tick();
    check3("load0001", 1'b0, 1'b0, 1'b0, 1'b0);
    par4 = 4'b1000;
    shift_word("w0001", 1'b0, 8'b0000_0001, 4);
    tick();
    check3("load1000", 1'b0, 1'b0, 1'b0, 1'b0);
    // Output order 0,0,0,1
    shift_word("w1000", 1'b0, 8'b0000_1000, 4);

    // Reset after two bits of 4'b1111
    par4 = 4'b1111;
    tick();
    check3("load1111", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check3("w1111.bit0", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check3("w1111.bit1", 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check3("midreset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    par4  = 4'b0101;
    tick();
    check3("load0101", 1'b0, 1'b0, 1'b0, 1'b0);
    // Fresh word: 1,0,1,0
    shift_word("w0101", 1'b0, 8'b0000_0101, 4);

    // 8-bit MSB first: 8'hA5 -> 1,0,1,0,0,1,0,1 (output order)
    par8   = 8'hA5;
    reset8 = 1'b0;
    tick();
    check3("loadA5", 1'b1, 1'b0, 1'b0, 1'b0);
    par8 = 8'h00;
    shift_word("wA5", 1'b1, 8'b1010_0101, 8);
    tick();
    check3("load00", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
